pipe_flow_ctrl: RTL
===================

# pipe_flow_ctrl

Pipeline flow controller that consumes the hazard detector's stall request and the branch misprediction flag and turns them into the per-stage write enables, flushes and bubble inserts of the 16-bit five-stage pipeline. It sits between the hazard/branch-prediction logic and the PC, IF/ID and ID/EX registers. It owns the stall/flush state machine, a stall watchdog and two saturating performance counters.

## Interface

Parameters:
- STALL_MAX, default 4: consecutive stalled cycles that set the watchdog error.
- CNT_W, default 16: width of each performance counter.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall_req  in  1  RAW-hazard stall request (PC-stall output of the hazard detector), combinational, same cycle.
- mispredict  in  1  branch misprediction flag, valid in the cycle it is high.
- pc_we  out  1  PC register write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  load NOP (16'h0000) into IF/ID.
- idex_bubble  out  1  load NOP and clear control bits in ID/EX.
- redirect  out  1  PC mux selects the branch-correction target.
- state  out  2  current FSM state.
- stall_cnt  out  CNT_W  cycles lost to stalls, saturating.
- flush_cnt  out  CNT_W  accepted mispredictions, saturating.
- wd_err  out  1  sticky watchdog error.

## Operation

- States: HOLD=0, RUN=1, STALL=2, FLUSH=3. Outputs are combinational from state and inputs, so a stall takes effect in the cycle it is requested.
- Input priority: reset, then mispredict, then stall_req.
- HOLD
  - Outputs: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, redirect=0.
  - Next state: RUN after one clock with reset low.
- RUN or STALL, mispredict=1
  - Outputs: redirect=1, pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1.
  - Next state: FLUSH. flush_cnt increments. Any stall_req in the same cycle is discarded.
- RUN or STALL, mispredict=0, stall_req=1
  - Outputs: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1, redirect=0.
  - Next state: STALL. stall_cnt increments.
- RUN or STALL, both inputs low
  - Outputs: pc_we=1, ifid_we=1, other outputs 0.
  - Next state: RUN.
- FLUSH (one cycle, squashes the second wrong-path slot)
  - Outputs: idex_bubble=1, redirect=0, ifid_flush=0, pc_we=ifid_we=!stall_req.
  - mispredict is ignored, because the flagged branch is already squashed.
  - Next state: STALL if stall_req, else RUN. stall_cnt increments if stall_req.
- Watchdog
  - Internal consecutive-stall counter (width clog2(STALL_MAX+1)) increments each cycle the STALL outputs are driven and clears on any non-stall cycle.
  - When the counter reaches STALL_MAX, wd_err sets. It clears only on reset.
- Counters stop at 2^CNT_W-1; there is no wrap.

## Timing

- Reset values: state=HOLD, stall_cnt=0, flush_cnt=0, wd_err=0, watchdog counter=0. Outputs take HOLD values immediately on assertion, with no clock needed.
- Reset asserted mid-FLUSH or mid-STALL aborts the operation. HOLD persists for one clock edge after reset falls.
- Latency:
  - stall_req to pc_we low: 0 cycles (same cycle).
  - mispredict to redirect: 0 cycles.
  - Counter updates are visible on the next edge.
- Mispredict squash window: exactly two cycles of idex_bubble (accept cycle plus FLUSH).
- A stall_req held for N cycles in RUN gives exactly N cycles with pc_we=0.

## Structure

- Package pipe_ctrl_pkg holds:
  - the state encodings HOLD/RUN/STALL/FLUSH;
  - the NOP encoding 16'h0000;
  - the opcode constants (BEQ=3'd2).
- Sub-module sat_counter (parameter W; inputs clock, reset, inc; output count) is instantiated for stall_cnt and flush_cnt.

## Test plan

- Reset asserted, then released: outputs are HOLD values immediately with state=0; one edge later state=1, pc_we=1, ifid_we=1, counters 0.
- stall_req high for 3 cycles in RUN: pc_we=0 and idex_bubble=1 for exactly those 3 cycles; state=2; stall_cnt=3; wd_err=0 with STALL_MAX=4.
- mispredict for one cycle in RUN: redirect=1 and ifid_flush=1 that cycle; next cycle state=3 with idex_bubble=1; then RUN; flush_cnt=1.
- mispredict and stall_req high together while in STALL: flush wins (redirect=1, pc_we=1); stall_cnt unchanged; next state=3.
- stall_req held for 4 cycles with STALL_MAX=4: wd_err=1 after the 4th edge; it stays 1 after stall_req drops, until reset.
- CNT_W=3 with 9 mispredicts, each separated by a RUN cycle: flush_cnt saturates at 7.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and control-vector helpers for the pipeline flow controller.
package pipe_ctrl_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 3;

  // Flow-controller states; encodings are visible on the state port.
  typedef enum logic [STATE_W-1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } pipe_state_e;

  // Instruction word loaded into IF/ID on a flush.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  // Conditional branch opcode.
  localparam logic [OPC_W-1:0] OPC_BEQ = 3'd2;

  // Per-cycle controls driven into the PC, IF/ID and ID/EX registers.
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic redirect;
  } pipe_ctrl_t;

  // Pipeline frozen with NOPs in both front-end registers.
  function automatic pipe_ctrl_t ctrl_hold();
    pipe_ctrl_t c;
    c.pc_we       = 1'b0;
    c.ifid_we     = 1'b0;
    c.ifid_flush  = 1'b1;
    c.idex_bubble = 1'b1;
    c.redirect    = 1'b0;
    return c;
  endfunction

  // Normal advance of PC and IF/ID.
  function automatic pipe_ctrl_t ctrl_run();
    pipe_ctrl_t c;
    c.pc_we       = 1'b1;
    c.ifid_we     = 1'b1;
    c.ifid_flush  = 1'b0;
    c.idex_bubble = 1'b0;
    c.redirect    = 1'b0;
    return c;
  endfunction

  // Freeze PC and IF/ID, inject a bubble into ID/EX.
  function automatic pipe_ctrl_t ctrl_stall();
    pipe_ctrl_t c;
    c.pc_we       = 1'b0;
    c.ifid_we     = 1'b0;
    c.ifid_flush  = 1'b0;
    c.idex_bubble = 1'b1;
    c.redirect    = 1'b0;
    return c;
  endfunction

  // Accept a misprediction: load the correction target, squash both slots.
  function automatic pipe_ctrl_t ctrl_redirect();
    pipe_ctrl_t c;
    c.pc_we       = 1'b1;
    c.ifid_we     = 1'b1;
    c.ifid_flush  = 1'b1;
    c.idex_bubble = 1'b1;
    c.redirect    = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_flow_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: advance on inc unless already at the ceiling.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Stall/flush controller for the five-stage pipeline: turns hazard stall
// requests and branch mispredictions into PC / IF/ID / ID/EX controls, with a
// consecutive-stall watchdog and saturating stall/flush counters.
module pipe_flow_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_MAX = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall_req,
  input  logic             mispredict,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             redirect,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             wd_err
);

  localparam int unsigned WD_W = $clog2(STALL_MAX + 1);

  pipe_state_e state_q;
  pipe_state_e state_d;
  pipe_ctrl_t  ctrl;
  logic        stall_inc;
  logic        flush_inc;
  logic [WD_W-1:0] wd_cnt_q;
  logic [WD_W-1:0] wd_cnt_d;
  logic        wd_err_q;
  logic        wd_err_d;

  // State register; reset drops straight to HOLD so outputs follow at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and combinational controls; mispredict outranks stall_req.
  always_comb begin
    state_d   = state_q;
    ctrl      = ctrl_run();
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      ST_HOLD: begin
        ctrl    = ctrl_hold();
        state_d = ST_RUN;
      end
      ST_RUN, ST_STALL: begin
        if (mispredict) begin
          ctrl      = ctrl_redirect();
          flush_inc = 1'b1;
          state_d   = ST_FLUSH;
        end else if (stall_req) begin
          ctrl      = ctrl_stall();
          stall_inc = 1'b1;
          state_d   = ST_STALL;
        end else begin
          ctrl    = ctrl_run();
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Second squash slot; the branch is already handled, so mispredict
        // is ignored, but a stall still freezes the front end.
        ctrl             = ctrl_stall();
        ctrl.pc_we       = !stall_req;
        ctrl.ifid_we     = !stall_req;
        if (stall_req) begin
          stall_inc = 1'b1;
          state_d   = ST_STALL;
        end else begin
          state_d   = ST_RUN;
        end
      end
      default: begin
        ctrl    = ctrl_hold();
        state_d = ST_HOLD;
      end
    endcase
  end

  // Watchdog next state: count consecutive stalled cycles, latch error sticky.
  always_comb begin
    wd_cnt_d = '0;
    if (stall_inc) begin
      if (wd_cnt_q == WD_W'(STALL_MAX)) begin
        wd_cnt_d = wd_cnt_q;
      end else begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
    end
    wd_err_d = wd_err_q | (wd_cnt_d == WD_W'(STALL_MAX));
  end

  // Watchdog registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign pc_we       = ctrl.pc_we;
  assign ifid_we     = ctrl.ifid_we;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign redirect    = ctrl.redirect;
  assign state       = state_q;
  assign wd_err      = wd_err_q;

endmodule
